// File: rtl/core_dispatcher.sv
// Event dispatcher in front of core_monitor: pops the event queue onto idle cores and
// collects completed-event returns, issuing at most one send or one return per cycle.
module core_dispatcher #(
   parameter int NUM_CORE  = 4,
   parameter int NB_COREID = $clog2(NUM_CORE),
   parameter int MSG_WID   = 32
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic [MSG_WID-1:0]          q_msg,
   input  logic                        q_vld,
   output logic                        q_deq,
   input  logic                        dispatch_en,
   input  logic [NUM_CORE-1:0]         core_rtn_vld,
   input  logic [NUM_CORE*MSG_WID-1:0] core_rtn_msg,
   output logic [NUM_CORE-1:0]         core_rtn_ack,
   output logic [NUM_CORE-1:0]         core_start,
   output logic [MSG_WID-1:0]          core_msg,
   output logic [MSG_WID-1:0]          mon_msg,
   output logic                        mon_sent_vld,
   output logic                        mon_rcv_vld,
   output logic [NB_COREID-1:0]        mon_core_id,
   output logic [NUM_CORE-1:0]         core_active,
   output logic [NB_COREID:0]          inflight
);

   typedef enum logic {ST_ARB, ST_WAIT} state_t;

   state_t                state_q, state_d;
   logic [NB_COREID-1:0]  rr_ptr_q, rr_ptr_d;
   logic [NUM_CORE-1:0]   active_q, active_d, ack_q, ack_d, start_q, start_d;
   logic                  deq_q, deq_d, sent_q, sent_d, rcv_q, rcv_d;
   logic [MSG_WID-1:0]    core_msg_q, core_msg_d, mon_msg_q, mon_msg_d;
   logic [NB_COREID-1:0]  mon_id_q, mon_id_d;
   logic [NB_COREID:0]    inflight_q, inflight_d;

   logic [NUM_CORE-1:0]   rtn_elig, idle_elig;
   logic                  rtn_found, idle_found;
   logic [NB_COREID-1:0]  rtn_idx, idle_idx, scan_idx;

   function automatic logic [NB_COREID:0] popcnt(input logic [NUM_CORE-1:0] v);
      logic [NB_COREID:0] c;
      c = '0;
      for (int i = 0; i < NUM_CORE; i++) c = c + {{NB_COREID{1'b0}}, v[i]};
      return c;
   endfunction

   // A core waiting for its ack to be seen is neither returnable nor idle.
   always_comb begin
      rtn_elig   = core_rtn_vld & active_q;
      idle_elig  = ~active_q & ~core_rtn_vld;
      rtn_found  = 1'b0;
      rtn_idx    = '0;
      idle_found = 1'b0;
      idle_idx   = '0;
      scan_idx   = '0;
      for (int i = 0; i < NUM_CORE; i++) begin
         scan_idx = rr_ptr_q + i[NB_COREID-1:0];
         if (!rtn_found && rtn_elig[scan_idx]) begin
            rtn_found = 1'b1;
            rtn_idx   = scan_idx;
         end
      end
      for (int i = 0; i < NUM_CORE; i++) begin
         if (!idle_found && idle_elig[i]) begin
            idle_found = 1'b1;
            idle_idx   = i[NB_COREID-1:0];
         end
      end
   end

   always_comb begin
      state_d    = ST_ARB;
      rr_ptr_d   = rr_ptr_q;
      active_d   = active_q;
      ack_d      = '0;
      start_d    = '0;
      deq_d      = 1'b0;
      sent_d     = 1'b0;
      rcv_d      = 1'b0;
      core_msg_d = core_msg_q;
      mon_msg_d  = mon_msg_q;
      mon_id_d   = mon_id_q;
      if (rtn_found) begin
         ack_d[rtn_idx]    = 1'b1;
         rcv_d             = 1'b1;
         mon_msg_d         = core_rtn_msg[rtn_idx*MSG_WID +: MSG_WID];
         mon_id_d          = rtn_idx;
         active_d[rtn_idx] = 1'b0;
         rr_ptr_d          = rtn_idx + NB_COREID'(1);
      end else if (state_q == ST_ARB && q_vld && dispatch_en && idle_found) begin
         deq_d              = 1'b1;
         start_d[idle_idx]  = 1'b1;
         sent_d             = 1'b1;
         core_msg_d         = q_msg;
         mon_msg_d          = q_msg;
         mon_id_d           = idle_idx;
         active_d[idle_idx] = 1'b1;
         // Give the queue one cycle to present its new head after the pop.
         state_d            = ST_WAIT;
      end
      inflight_d = popcnt(active_d);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= ST_ARB;
         rr_ptr_q   <= '0;
         active_q   <= '0;
         ack_q      <= '0;
         start_q    <= '0;
         deq_q      <= 1'b0;
         sent_q     <= 1'b0;
         rcv_q      <= 1'b0;
         core_msg_q <= '0;
         mon_msg_q  <= '0;
         mon_id_q   <= '0;
         inflight_q <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         active_q   <= active_d;
         ack_q      <= ack_d;
         start_q    <= start_d;
         deq_q      <= deq_d;
         sent_q     <= sent_d;
         rcv_q      <= rcv_d;
         core_msg_q <= core_msg_d;
         mon_msg_q  <= mon_msg_d;
         mon_id_q   <= mon_id_d;
         inflight_q <= inflight_d;
      end
   end

   assign q_deq        = deq_q;
   assign core_rtn_ack = ack_q;
   assign core_start   = start_q;
   assign core_msg     = core_msg_q;
   assign mon_msg      = mon_msg_q;
   assign mon_sent_vld = sent_q;
   assign mon_rcv_vld  = rcv_q;
   assign mon_core_id  = mon_id_q;
   assign core_active  = active_q;
   assign inflight     = inflight_q;

endmodule

// File: tb/tb_core_dispatcher.sv
// Bench for core_dispatcher: directed scenarios plus a randomized run against a
// per-cycle reference model of the dispatch/return rules.
module tb_core_dispatcher;
   localparam int N   = 4;
   localparam int W   = 32;
   localparam int IDW = 2;

   logic           clk = 1'b0;
   logic           reset_n;
   logic [W-1:0]   q_msg;
   logic           q_vld;
   logic           q_deq;
   logic           dispatch_en;
   logic [N-1:0]   core_rtn_vld;
   logic [N*W-1:0] core_rtn_msg;
   logic [N-1:0]   core_rtn_ack;
   logic [N-1:0]   core_start;
   logic [W-1:0]   core_msg;
   logic [W-1:0]   mon_msg;
   logic           mon_sent_vld;
   logic           mon_rcv_vld;
   logic [IDW-1:0] mon_core_id;
   logic [N-1:0]   core_active;
   logic [IDW:0]   inflight;

   int checks = 0;
   int errors = 0;

   core_dispatcher #(.NUM_CORE(N), .NB_COREID(IDW), .MSG_WID(W)) dut (
      .clk(clk), .reset_n(reset_n), .q_msg(q_msg), .q_vld(q_vld), .q_deq(q_deq),
      .dispatch_en(dispatch_en), .core_rtn_vld(core_rtn_vld), .core_rtn_msg(core_rtn_msg),
      .core_rtn_ack(core_rtn_ack), .core_start(core_start), .core_msg(core_msg),
      .mon_msg(mon_msg), .mon_sent_vld(mon_sent_vld), .mon_rcv_vld(mon_rcv_vld),
      .mon_core_id(mon_core_id), .core_active(core_active), .inflight(inflight)
   );

   always #5 clk = ~clk;

   // Reference model: which cores hold events, where the return search starts,
   // and whether the previous cycle popped the queue.
   logic [N-1:0]   m_active, e_ack, e_start;
   logic           e_deq, e_sent, e_rcv, m_wait;
   logic [W-1:0]   e_mon_msg, e_core_msg;
   logic [IDW-1:0] e_id;
   int             m_ptr;

   always @(posedge clk) begin
      int g, d, k;
      if (!reset_n) begin
         m_active = '0; e_ack = '0; e_start = '0; e_deq = 0; e_sent = 0; e_rcv = 0;
         m_wait = 0; e_mon_msg = '0; e_core_msg = '0; e_id = '0; m_ptr = 0;
      end else begin
         e_ack = '0; e_start = '0; e_deq = 0; e_sent = 0; e_rcv = 0;
         g = -1; d = -1;
         for (int i = 0; i < N; i++) begin
            k = (m_ptr + i) % N;
            if (g < 0 && core_rtn_vld[k] && m_active[k]) g = k;
         end
         for (int i = N - 1; i >= 0; i--)
            if (!m_active[i] && !core_rtn_vld[i]) d = i;
         if (g >= 0) begin
            e_ack[g] = 1; e_rcv = 1; e_mon_msg = core_rtn_msg[g*W +: W];
            e_id = g[IDW-1:0]; m_active[g] = 0; m_ptr = (g + 1) % N; m_wait = 0;
         end else if (!m_wait && q_vld && dispatch_en && d >= 0) begin
            e_start[d] = 1; e_deq = 1; e_sent = 1; e_mon_msg = q_msg; e_core_msg = q_msg;
            e_id = d[IDW-1:0]; m_active[d] = 1; m_wait = 1;
         end else begin
            m_wait = 0;
         end
      end
   end

   function automatic int count_ones(input logic [N-1:0] v);
      int c = 0;
      for (int i = 0; i < N; i++) c += v[i];
      return c;
   endfunction

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset_n = 0; q_vld = 1; q_msg = 32'hDEAD_BEEF; dispatch_en = 1;
      core_rtn_vld = '1; core_rtn_msg = {$urandom, $urandom, $urandom, $urandom};
      cyc(); cyc();
      checks++; if (q_deq !== 1'b0) begin errors++; $display("FAIL reset_q_deq got %b want 0", q_deq); end
      checks++; if (core_start !== '0 || core_rtn_ack !== '0) begin errors++; $display("FAIL reset_start_ack got %b/%b want 0/0", core_start, core_rtn_ack); end
      checks++; if (mon_sent_vld !== 1'b0 || mon_rcv_vld !== 1'b0) begin errors++; $display("FAIL reset_mon_vld got %b/%b want 0/0", mon_sent_vld, mon_rcv_vld); end
      checks++; if (mon_msg !== '0 || core_msg !== '0 || mon_core_id !== '0) begin errors++; $display("FAIL reset_data got %h/%h/%0d want 0", mon_msg, core_msg, mon_core_id); end
      checks++; if (core_active !== '0 || inflight !== '0) begin errors++; $display("FAIL reset_active got %b/%0d want 0/0", core_active, inflight); end
      reset_n = 1; q_vld = 0; core_rtn_vld = '0;
   endtask

   task automatic test_dispatch();
      q_vld = 1; q_msg = 32'h0003_0010;
      cyc();
      checks++; if (q_deq !== 1'b1 || core_start !== 4'b0001) begin errors++; $display("FAIL disp_first got deq=%b start=%b want 1/0001", q_deq, core_start); end
      checks++; if (mon_sent_vld !== 1'b1 || mon_rcv_vld !== 1'b0 || mon_core_id !== 2'd0) begin errors++; $display("FAIL disp_mon got sent=%b rcv=%b id=%0d want 1/0/0", mon_sent_vld, mon_rcv_vld, mon_core_id); end
      checks++; if (mon_msg !== 32'h0003_0010 || core_msg !== 32'h0003_0010) begin errors++; $display("FAIL disp_msg got %h/%h want 00030010", mon_msg, core_msg); end
      checks++; if (core_active !== 4'b0001 || inflight !== 3'd1) begin errors++; $display("FAIL disp_active got %b/%0d want 0001/1", core_active, inflight); end
      q_msg = 32'h0003_0011;
      cyc();
      checks++; if (q_deq !== 1'b0 || core_start !== '0 || mon_sent_vld !== 1'b0) begin errors++; $display("FAIL disp_wait got deq=%b start=%b sent=%b want 0", q_deq, core_start, mon_sent_vld); end
   endtask

   task automatic test_fill();
      logic [N-1:0] want;
      int extra_deq = 0;
      for (int d = 1; d < N; d++) begin
         cyc();
         want = '0; want[d] = 1'b1;
         checks++; if (q_deq !== 1'b1 || core_start !== want || mon_core_id !== d[IDW-1:0]) begin errors++; $display("FAIL fill_dispatch%0d got deq=%b start=%b id=%0d want 1/%b/%0d", d, q_deq, core_start, mon_core_id, want, d); end
         checks++; if (mon_msg !== 32'h0003_0010 + d) begin errors++; $display("FAIL fill_msg%0d got %h want %h", d, mon_msg, 32'h0003_0010 + d); end
         q_msg = 32'h0003_0010 + d + 1;
         cyc();
         checks++; if (q_deq !== 1'b0) begin errors++; $display("FAIL fill_wait%0d got deq=%b want 0", d, q_deq); end
      end
      checks++; if (core_active !== 4'hF || inflight !== 3'd4) begin errors++; $display("FAIL fill_full got %b/%0d want 1111/4", core_active, inflight); end
      for (int c = 0; c < 4; c++) begin
         cyc();
         if (q_deq !== 1'b0 || core_start !== '0) extra_deq++;
      end
      checks++; if (extra_deq != 0) begin errors++; $display("FAIL fill_no_deq got %0d dispatch cycles want 0", extra_deq); end
      q_vld = 0;
   endtask

   task automatic test_return_rr();
      logic [N-1:0] want_act;
      for (int k = 0; k < N; k++) core_rtn_msg[k*W +: W] = 32'h5200_0000 | k;
      core_rtn_vld = 4'hF;
      for (int k = 0; k < N; k++) begin
         cyc();
         want_act = 4'hF << (k + 1);
         checks++; if (core_rtn_ack !== (4'b0001 << k) || mon_rcv_vld !== 1'b1 || mon_sent_vld !== 1'b0) begin errors++; $display("FAIL rr_ack%0d got ack=%b rcv=%b sent=%b", k, core_rtn_ack, mon_rcv_vld, mon_sent_vld); end
         checks++; if (mon_core_id !== k[IDW-1:0] || mon_msg !== (32'h5200_0000 | k)) begin errors++; $display("FAIL rr_mon%0d got id=%0d msg=%h want %0d/%h", k, mon_core_id, mon_msg, k, 32'h5200_0000 | k); end
         checks++; if (core_active !== want_act) begin errors++; $display("FAIL rr_active%0d got %b want %b", k, core_active, want_act); end
         core_rtn_vld[k] = 1'b0;
      end
      checks++; if (inflight !== 3'd0) begin errors++; $display("FAIL rr_inflight got %0d want 0", inflight); end
   endtask

   task automatic test_conflict();
      q_vld = 1; q_msg = 32'hA000_0000;
      cyc();
      checks++; if (core_start !== 4'b0001) begin errors++; $display("FAIL cf_setup0 got %b want 0001", core_start); end
      q_msg = 32'hA000_0001;
      cyc(); cyc();
      checks++; if (core_start !== 4'b0010) begin errors++; $display("FAIL cf_setup1 got %b want 0010", core_start); end
      q_msg = 32'hA000_0002;
      cyc(); cyc();
      checks++; if (core_start !== 4'b0100) begin errors++; $display("FAIL cf_setup2 got %b want 0100", core_start); end
      q_vld = 0;
      cyc();
      core_rtn_vld[0] = 1'b1; core_rtn_msg[0 +: W] = 32'hC0C0_0000;
      cyc();
      checks++; if (core_rtn_ack !== 4'b0001) begin errors++; $display("FAIL cf_ret0 got %b want 0001", core_rtn_ack); end
      core_rtn_vld[0] = 1'b0;
      core_rtn_vld[2] = 1'b1; core_rtn_msg[2*W +: W] = 32'hC0C0_0002;
      q_vld = 1; q_msg = 32'hB000_0000;
      cyc();
      checks++; if (core_rtn_ack !== 4'b0100 || mon_rcv_vld !== 1'b1 || mon_core_id !== 2'd2 || mon_msg !== 32'hC0C0_0002) begin errors++; $display("FAIL cf_return_first got ack=%b rcv=%b id=%0d msg=%h", core_rtn_ack, mon_rcv_vld, mon_core_id, mon_msg); end
      checks++; if (mon_sent_vld !== 1'b0 || q_deq !== 1'b0 || core_start !== '0) begin errors++; $display("FAIL cf_no_send got sent=%b deq=%b start=%b want 0", mon_sent_vld, q_deq, core_start); end
      core_rtn_vld[2] = 1'b0;
      cyc();
      checks++; if (core_start !== 4'b0001 || q_deq !== 1'b1 || mon_sent_vld !== 1'b1 || mon_rcv_vld !== 1'b0) begin errors++; $display("FAIL cf_dispatch_after got start=%b deq=%b sent=%b rcv=%b", core_start, q_deq, mon_sent_vld, mon_rcv_vld); end
      checks++; if (mon_core_id !== 2'd0 || mon_msg !== 32'hB000_0000 || core_active !== 4'b0011) begin errors++; $display("FAIL cf_state got id=%0d msg=%h act=%b want 0/B0000000/0011", mon_core_id, mon_msg, core_active); end
      q_vld = 0;
      cyc();
   endtask

   task automatic test_dispatch_en();
      int bad = 0;
      dispatch_en = 0; q_vld = 1; q_msg = 32'hC000_0000;
      for (int c = 0; c < 3; c++) begin
         cyc();
         if (q_deq !== 1'b0 || core_start !== '0) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL den_blocked got %0d dispatch cycles want 0", bad); end
      dispatch_en = 1;
      cyc();
      checks++; if (q_deq !== 1'b1 || core_start !== 4'b0100 || mon_msg !== 32'hC000_0000) begin errors++; $display("FAIL den_release got deq=%b start=%b msg=%h want 1/0100/C0000000", q_deq, core_start, mon_msg); end
      checks++; if (core_active !== 4'b0111 || inflight !== 3'd3) begin errors++; $display("FAIL den_active got %b/%0d want 0111/3", core_active, inflight); end
      reset_n = 0;
      cyc();
      checks++; if (core_active !== '0 || inflight !== '0 || q_deq !== 1'b0 || mon_sent_vld !== 1'b0) begin errors++; $display("FAIL midreset got act=%b infl=%0d deq=%b sent=%b want 0", core_active, inflight, q_deq, mon_sent_vld); end
      reset_n = 1; q_vld = 0;
   endtask

   task automatic test_random();
      logic [W-1:0] q[$];
      logic [N-1:0] busy = '0;
      reset_n = 0; q_vld = 0; core_rtn_vld = '0; dispatch_en = 1;
      cyc(); cyc();
      reset_n = 1;
      for (int c = 0; c < 1500; c++) begin
         cyc();
         checks++; if (q_deq !== e_deq || core_start !== e_start) begin errors++; $display("FAIL rnd_dispatch c%0d got deq=%b start=%b want %b/%b", c, q_deq, core_start, e_deq, e_start); end
         checks++; if (core_rtn_ack !== e_ack) begin errors++; $display("FAIL rnd_ack c%0d got %b want %b", c, core_rtn_ack, e_ack); end
         checks++; if (mon_sent_vld !== e_sent || mon_rcv_vld !== e_rcv) begin errors++; $display("FAIL rnd_mon_vld c%0d got %b/%b want %b/%b", c, mon_sent_vld, mon_rcv_vld, e_sent, e_rcv); end
         checks++; if (mon_msg !== e_mon_msg || mon_core_id !== e_id) begin errors++; $display("FAIL rnd_mon_data c%0d got %h/%0d want %h/%0d", c, mon_msg, mon_core_id, e_mon_msg, e_id); end
         checks++; if (core_active !== m_active || inflight !== count_ones(m_active)) begin errors++; $display("FAIL rnd_active c%0d got %b/%0d want %b/%0d", c, core_active, inflight, m_active, count_ones(m_active)); end
         if (e_start != '0) begin
            checks++; if (core_msg !== e_core_msg) begin errors++; $display("FAIL rnd_core_msg c%0d got %h want %h", c, core_msg, e_core_msg); end
         end
         // Core and queue behaviour for the next cycle.
         for (int i = 0; i < N; i++) begin
            if (core_rtn_ack[i]) begin
               core_rtn_vld[i] = 0; busy[i] = 0;
            end else if (core_start[i]) begin
               busy[i] = 1;
            end else if (busy[i] && !core_rtn_vld[i] && $urandom_range(0, 3) == 0) begin
               core_rtn_vld[i] = 1; core_rtn_msg[i*W +: W] = $urandom;
            end else if (!busy[i] && !core_rtn_vld[i] && $urandom_range(0, 15) == 0) begin
               core_rtn_vld[i] = 1; core_rtn_msg[i*W +: W] = $urandom;
            end else if (!busy[i] && core_rtn_vld[i] && $urandom_range(0, 2) == 0) begin
               core_rtn_vld[i] = 0;
            end
         end
         if (q_deq && q.size() > 0) void'(q.pop_front());
         if (q.size() < 8 && $urandom_range(0, 2) == 0) q.push_back($urandom);
         q_vld = (q.size() > 0);
         q_msg = (q.size() > 0) ? q[0] : W'($urandom);
         dispatch_en = ($urandom_range(0, 7) != 0);
         if (!reset_n) begin
            reset_n = 1;
         end else if ($urandom_range(0, 299) == 0) begin
            reset_n = 0; busy = '0; core_rtn_vld = '0;
         end
      end
      reset_n = 1; q_vld = 0; core_rtn_vld = '0;
   endtask

   initial begin
      reset_n = 0; q_vld = 0; q_msg = '0; dispatch_en = 1;
      core_rtn_vld = '0; core_rtn_msg = '0;
      test_reset();
      test_dispatch();
      test_fill();
      test_return_rr();
      test_conflict();
      test_dispatch_en();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
